// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, addresses the synchronous ROM, and presents a registered instruction
// with a one-entry stall skid, 2-word squash on taken branches and sticky halt. Option macro: FETCH_LUT_EN.
module instr_fetch #(
    parameter int unsigned   PC_W      = 10,
    parameter int unsigned   IW        = 9,
    parameter logic [IW-1:0] HALT_CODE = IW'(9'h1FF)
`ifdef FETCH_LUT_EN
    ,
    parameter int unsigned   LUT_AW    = 4
`endif
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_stall,
    input  logic              i_branch,
    input  logic              i_taken,
`ifdef FETCH_LUT_EN
    input  logic [LUT_AW-1:0] i_target,
    input  logic              i_lut_we,
    input  logic [LUT_AW-1:0] i_lut_addr,
    input  logic [PC_W-1:0]   i_lut_data,
`else
    input  logic [PC_W-1:0]   i_target,
`endif
    output logic [PC_W-1:0]   o_rom_addr,
    input  logic [IW-1:0]     i_rom_data,
    output logic [IW-1:0]     o_instr,
    output logic              o_instr_valid,
    output logic [PC_W-1:0]   o_instr_pc,
    output logic              o_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [PC_W-1:0] r_fetch_pc, w_fetch_pc_nxt;
    logic [PC_W-1:0] r_data_pc;
    logic [IW-1:0]   r_instr, w_instr_nxt;
    logic            r_instr_valid, w_instr_valid_nxt;
    logic [PC_W-1:0] r_instr_pc, w_instr_pc_nxt;
    logic            r_done, w_done_nxt;
    logic [IW-1:0]   r_skid_data, w_skid_data_nxt;
    logic [PC_W-1:0] r_skid_pc, w_skid_pc_nxt;
    logic            r_skid_full, w_skid_full_nxt;
    logic            r_skid_live, w_skid_live_nxt;
    logic            r_squash, w_squash_nxt;
    logic [PC_W-1:0] w_target;
    logic            w_halt;
    logic            w_redirect;

`ifdef FETCH_LUT_EN
    localparam int unsigned LUT_DEPTH = 2 ** LUT_AW;

    logic [PC_W-1:0] r_lut [LUT_DEPTH];

    // Branch target table; a lookup in the same cycle as a write sees the old entry
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lut <= '{default: '0};
        end else if (i_lut_we) begin
            r_lut[i_lut_addr] <= i_lut_data;
        end
    end

    assign w_target = r_lut[i_target];
`else
    assign w_target = i_target;
`endif

    assign w_halt     = r_instr_valid && (r_instr == HALT_CODE);
    assign w_redirect = i_branch && i_taken && r_instr_valid;

    // r_squash marks the word now on the ROM output as dead (fill or wrong-path fetch)
    always_comb begin
        w_state_nxt       = r_state;
        w_fetch_pc_nxt    = r_fetch_pc;
        w_instr_nxt       = r_instr;
        w_instr_valid_nxt = r_instr_valid;
        w_instr_pc_nxt    = r_instr_pc;
        w_done_nxt        = r_done;
        w_skid_data_nxt   = r_skid_data;
        w_skid_pc_nxt     = r_skid_pc;
        w_skid_full_nxt   = r_skid_full;
        w_skid_live_nxt   = r_skid_live;
        w_squash_nxt      = r_squash;

        case (r_state)
            ST_IDLE, ST_HALT: begin
                if (i_start) begin
                    w_state_nxt       = ST_FILL;
                    w_fetch_pc_nxt    = '0;
                    w_done_nxt        = 1'b0;
                    w_instr_valid_nxt = 1'b0;
                    w_skid_full_nxt   = 1'b0;
                    w_squash_nxt      = 1'b1;
                end
            end
            ST_FILL, ST_RUN: begin
                if (r_state == ST_FILL) begin
                    w_state_nxt = ST_RUN;
                end
                if (i_stall) begin
                    if (!r_skid_full) begin
                        w_skid_data_nxt = i_rom_data;
                        w_skid_pc_nxt   = r_data_pc;
                        w_skid_live_nxt = !r_squash;
                        w_skid_full_nxt = 1'b1;
                        w_squash_nxt    = 1'b0;
                    end
                end else if (w_halt) begin
                    w_state_nxt       = ST_HALT;
                    w_done_nxt        = 1'b1;
                    w_instr_valid_nxt = 1'b0;
                    w_skid_full_nxt   = 1'b0;
                    w_squash_nxt      = 1'b0;
                end else if (w_redirect) begin
                    // Current ROM word is wrong-path; the one in flight is dropped next edge
                    w_fetch_pc_nxt    = w_target;
                    w_instr_valid_nxt = 1'b0;
                    w_skid_full_nxt   = 1'b0;
                    w_squash_nxt      = 1'b1;
                end else begin
                    w_fetch_pc_nxt = r_fetch_pc + PC_W'(1);
                    if (r_skid_full) begin
                        // ROM re-reads the held address, so its current word is not consumed
                        w_instr_nxt       = r_skid_data;
                        w_instr_pc_nxt    = r_skid_pc;
                        w_instr_valid_nxt = r_skid_live;
                        w_skid_full_nxt   = 1'b0;
                    end else begin
                        w_instr_nxt       = i_rom_data;
                        w_instr_pc_nxt    = r_data_pc;
                        w_instr_valid_nxt = !r_squash;
                        w_squash_nxt      = 1'b0;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_fetch_pc    <= '0;
            r_data_pc     <= '0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_instr_pc    <= '0;
            r_done        <= 1'b0;
            r_skid_data   <= '0;
            r_skid_pc     <= '0;
            r_skid_full   <= 1'b0;
            r_skid_live   <= 1'b0;
            r_squash      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_data_pc     <= r_fetch_pc;
            r_instr       <= w_instr_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
            r_done        <= w_done_nxt;
            r_skid_data   <= w_skid_data_nxt;
            r_skid_pc     <= w_skid_pc_nxt;
            r_skid_full   <= w_skid_full_nxt;
            r_skid_live   <= w_skid_live_nxt;
            r_squash      <= w_squash_nxt;
        end
    end

    assign o_rom_addr    = r_fetch_pc;
    assign o_instr       = r_instr;
    assign o_instr_valid = r_instr_valid;
    assign o_instr_pc    = r_instr_pc;
    assign o_done        = r_done;

endmodule
